// File: rtl/song_sequencer.sv
// song_sequencer: tempo-driven playback controller.
// Walks note positions 0..SONG_LEN-1. Each note is fetched from song storage
// over a req/ack port and then presented for one beat of TICK_DIV cycles.
// Playback supports start, pause and stop, and signals the end of the song.
// Build option: define SONG_SEQ_LOOP_EN to repeat the song until stop. In that
// build, done pulses at each wrap back to position 0.
module song_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int SONG_LEN = 32,
  parameter int AW       = 5
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  input  logic [1:0]    rd_note,
  output logic [1:0]    note_out,
  output logic          note_valid,
  output logic [AW-1:0] position,
  output logic          busy,
  output logic          done
);

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] BEAT_LAST = CW'(TICK_DIV - 1);
  localparam logic [AW-1:0] POS_LAST  = AW'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] position_q, position_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]    note_q, note_d;
  logic          note_valid_q, note_valid_d;
  logic          done_q, done_d;

  // State register plus datapath registers, all cleared by the async reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      position_q   <= '0;
      beat_cnt_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      state_q      <= state_d;
      position_q   <= position_d;
      beat_cnt_q   <= beat_cnt_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic. stop overrides every state, including a start in the same cycle.
  always_comb begin
    // NOTE: defaults first so that no path leaves a signal unassigned (no latches).
    state_d      = state_q;
    position_d   = position_q;
    beat_cnt_d   = beat_cnt_q;
    note_d       = note_q;
    note_valid_d = 1'b0;
    done_d       = 1'b0;

    if (stop) begin
      state_d    = S_IDLE;
      position_d = '0;
      beat_cnt_d = '0;
      note_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_FETCH;
            position_d = '0;
            beat_cnt_d = '0;
          end
        end
        S_FETCH: begin
          // Wait for storage with no timeout. The note and its valid pulse land together.
          if (rd_ack) begin
            note_d       = rd_note;
            note_valid_d = 1'b1;
            beat_cnt_d   = '0;
            state_d      = S_PLAY;
          end
        end
        S_PLAY: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            if (position_q == POS_LAST) begin
              done_d = 1'b1;
`ifdef SONG_SEQ_LOOP_EN
              state_d    = S_FETCH;
              position_d = '0;
`else
              state_d    = S_DONE;
`endif
            end else begin
              position_d = position_q + AW'(1);
              state_d    = S_FETCH;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
        S_PAUSED: begin
          // The beat counter stays frozen. Counting resumes from the held value.
          if (!pause) state_d = S_PLAY;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Gating the request with stop lets storage see it withdrawn in the stop cycle itself.
  assign rd_req     = (state_q == S_FETCH) && !stop;
  assign rd_addr    = position_q;
  assign note_out   = note_q;
  assign note_valid = note_valid_q;
  assign position   = position_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_PLAY) || (state_q == S_PAUSED);
  assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed testbench for song_sequencer with TICK_DIV=4, SONG_LEN=4 and storage
// notes {1,2,3,0}. Storage acks one cycle after it first sees a request.
// Outputs are sampled on the falling edge. Inputs are also driven there.
module tb_song_sequencer;

  localparam int TICK_DIV = 4;
  localparam int SONG_LEN = 4;
  localparam int AW       = 5;

  logic          clk   = 1'b0;
  logic          nrst  = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          stop  = 1'b0;
  logic          rd_req, rd_ack, note_valid, busy, done;
  logic [AW-1:0] rd_addr, position;
  logic [1:0]    rd_note, note_out;

  logic          ack_en     = 1'b1;
  logic          model_ack  = 1'b0;
  logic          req_seen   = 1'b0;
  logic          force_ack  = 1'b0;
  logic [1:0]    model_note = 2'd0;
  logic [1:0]    force_note = 2'd0;
  logic [1:0]    song [4]   = '{2'd1, 2'd2, 2'd3, 2'd0};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_ack  = model_ack | force_ack;
  assign rd_note = force_ack ? force_note : model_note;

  song_sequencer #(.TICK_DIV(TICK_DIV), .SONG_LEN(SONG_LEN), .AW(AW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .pause(pause), .stop(stop),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_note(rd_note),
    .note_out(note_out), .note_valid(note_valid), .position(position),
    .busy(busy), .done(done)
  );

  // Storage model: ack (with data) one cycle after a request is first seen.
  always @(negedge clk) begin
    if (ack_en && rd_req) begin
      if (req_seen) begin
        model_ack  = 1'b1;
        model_note = song[rd_addr[1:0]];
      end
      req_seen = 1'b1;
    end else begin
      model_ack = 1'b0;
      req_seen  = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Bounded wait for the note_valid pulse at a given position.
  task automatic wait_nv(input logic [AW-1:0] pos, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (note_valid && position == pos) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: no note_valid at position %0d within 40 cycles", tag, pos);
    end
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({rd_req, rd_addr, note_out, note_valid, position, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rd_req, rd_addr, note_out, note_valid, position, busy, done});
    end
    tick();
    nrst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b rd_req=%b expected 0 0", busy, rd_req);
    end
  endtask

  task automatic test_reset_mid_play();
    pulse_start();
    wait_nv(AW'(1), "midplay_reach");
    checks++;
    if (note_out !== 2'd2) begin
      failures++;
      $display("FAIL midplay_note: got %0d expected 2", note_out);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({rd_req, rd_addr, note_out, note_valid, position, busy, done} !== '0) begin
      failures++;
      $display("FAIL midplay_reset_outputs: got %h expected 0",
               {rd_req, rd_addr, note_out, note_valid, position, busy, done});
    end
    @(negedge clk);
    nrst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      failures++;
      $display("FAIL midplay_idle: busy=%b rd_req=%b expected 0 0", busy, rd_req);
    end
  endtask

`ifndef SONG_SEQ_LOOP_EN
  task automatic test_full_play();
    logic [AW-1:0] addrs [4];
    logic [1:0]    notes [4];
    logic [1:0]    exp_notes [4];
    int   n_fetch, n_nv, n_done, last_nv, done_cyc;
    logic prev_req, busy_at_nv, busy_after;
    exp_notes = '{2'd1, 2'd2, 2'd3, 2'd0};
    n_fetch = 0; n_nv = 0; n_done = 0; last_nv = -100; done_cyc = -1;
    prev_req = 1'b0; busy_at_nv = 1'b0; busy_after = 1'b1;
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      if (rd_req && !prev_req) begin
        if (n_fetch < 4) addrs[n_fetch] = rd_addr;
        if (n_fetch > 0) begin
          checks++;
          if (c - last_nv !== TICK_DIV) begin
            failures++;
            $display("FAIL beat_period: got %0d cycles expected %0d", c - last_nv, TICK_DIV);
          end
        end
        n_fetch++;
      end
      prev_req = rd_req;
      if (note_valid) begin
        if (n_nv < 4) notes[n_nv] = note_out;
        n_nv++;
        last_nv = c;
        busy_at_nv = busy;
      end
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      tick();
    end
    checks++;
    if (n_fetch !== 4) begin
      failures++;
      $display("FAIL fetch_count: got %0d expected 4", n_fetch);
    end
    checks++;
    if (n_nv !== 4) begin
      failures++;
      $display("FAIL note_valid_count: got %0d expected 4", n_nv);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < n_fetch) begin
        checks++;
        if (addrs[k] !== AW'(k)) begin
          failures++;
          $display("FAIL fetch_addr[%0d]: got %0d expected %0d", k, addrs[k], k);
        end
      end
      if (k < n_nv) begin
        checks++;
        if (notes[k] !== exp_notes[k]) begin
          failures++;
          $display("FAIL note_seq[%0d]: got %0d expected %0d", k, notes[k], exp_notes[k]);
        end
      end
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL done_count: got %0d expected 1", n_done);
    end
    checks++;
    if (done_cyc - last_nv !== TICK_DIV) begin
      failures++;
      $display("FAIL done_timing: got %0d cycles after last note expected %0d",
               done_cyc - last_nv, TICK_DIV);
    end
    checks++;
    if (busy_at_nv !== 1'b1 || busy_after !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_profile: at_note=%b after_done=%b end=%b expected 1 0 0",
               busy_at_nv, busy_after, busy);
    end
  endtask
`else
  task automatic test_loop();
    logic [AW-1:0] addrs [8];
    int   n_fetch, n_done, busy_low;
    logic prev_req;
    n_fetch = 0; n_done = 0; busy_low = 0; prev_req = 1'b0;
    pulse_start();
    for (int c = 0; c < 50; c++) begin
      if (rd_req && !prev_req) begin
        if (n_fetch < 8) addrs[n_fetch] = rd_addr;
        n_fetch++;
      end
      prev_req = rd_req;
      if (!busy) busy_low++;
      if (done) begin
        n_done++;
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== '0) begin
          failures++;
          $display("FAIL loop_wrap_fetch: rd_req=%b rd_addr=%0d expected 1 0", rd_req, rd_addr);
        end
      end
      tick();
    end
    checks++;
    if (n_fetch < 8) begin
      failures++;
      $display("FAIL loop_fetch_count: got %0d expected at least 8", n_fetch);
    end
    for (int k = 0; k < 8; k++) begin
      if (k < n_fetch) begin
        checks++;
        if (addrs[k] !== AW'(k % 4)) begin
          failures++;
          $display("FAIL loop_addr[%0d]: got %0d expected %0d", k, addrs[k], k % 4);
        end
      end
    end
    checks++;
    if (n_done !== 2) begin
      failures++;
      $display("FAIL loop_done_count: got %0d expected 2", n_done);
    end
    checks++;
    if (busy_low !== 0) begin
      failures++;
      $display("FAIL loop_busy: low for %0d cycles expected 0", busy_low);
    end
    do_stop();
    checks++;
    if (busy !== 1'b0 || position !== '0) begin
      failures++;
      $display("FAIL loop_stop: busy=%b position=%0d expected 0 0", busy, position);
    end
  endtask
`endif

  task automatic test_pause();
    pulse_start();
    wait_nv(AW'(1), "pause_reach");
    tick();
    tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({rd_req, position, note_out} !== {1'b0, AW'(1), 2'd2}) begin
        failures++;
        $display("FAIL pause_hold[%0d]: rd_req=%b position=%0d note=%0d expected 0 1 2",
                 i, rd_req, position, note_out);
      end
    end
    pause = 1'b0;
    // Resume at count 2. Count 2 and count 3 remain, then the fetch for position 2.
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rd_req !== 1'b0) begin
        failures++;
        $display("FAIL pause_resume_early[%0d]: rd_req=%b expected 0", i, rd_req);
      end
    end
    tick();
    checks++;
    if (rd_req !== 1'b1 || rd_addr !== AW'(2)) begin
      failures++;
      $display("FAIL pause_resume_fetch: rd_req=%b rd_addr=%0d expected 1 2", rd_req, rd_addr);
    end
    do_stop();
    checks++;
    if (busy !== 1'b0 || position !== '0 || note_out !== 2'd0) begin
      failures++;
      $display("FAIL stop_clear: busy=%b position=%0d note=%0d expected 0 0 0",
               busy, position, note_out);
    end
  endtask

  task automatic test_stop_fetch();
    ack_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_req !== 1'b1 || rd_addr !== '0) begin
        failures++;
        $display("FAIL fetch_hold[%0d]: rd_req=%b rd_addr=%0d expected 1 0", i, rd_req, rd_addr);
      end
      tick();
    end
    do_stop();
    checks++;
    if ({rd_req, busy, done, position} !== '0) begin
      failures++;
      $display("FAIL stop_in_fetch: rd_req=%b busy=%b done=%b position=%0d expected all 0",
               rd_req, busy, done, position);
    end
    force_note = 2'd3;
    force_ack  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (note_out !== 2'd0 || note_valid !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL late_ack[%0d]: note=%0d note_valid=%b done=%b expected 0 0 0",
                 i, note_out, note_valid, done);
      end
    end
    force_ack = 1'b0;
    ack_en    = 1'b1;
    tick();
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_idle: busy=%b rd_req=%b expected 0 0", busy, rd_req);
    end
    pulse_start();
    wait_nv(AW'(1), "start_in_play_reach");
    tick();
    pulse_start();
    checks++;
    if ({busy, rd_req, position, note_out} !== {1'b1, 1'b0, AW'(1), 2'd2}) begin
      failures++;
      $display("FAIL start_in_play: busy=%b rd_req=%b position=%0d note=%0d expected 1 0 1 2",
               busy, rd_req, position, note_out);
    end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_reset_mid_play();
`ifdef SONG_SEQ_LOOP_EN
    test_loop();
`else
    test_full_play();
`endif
    test_pause();
    test_stop_fetch();
    test_start_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
